// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- multi-cycle multiply/divide unit for the EX stage.
//
// This unit receives the same forwarded operand pair as the single-cycle ALU.
// It accepts mult/multu/div/divu, holds busy for a fixed latency and then
// writes HI/LO. mthi/mtlo write one register at the next edge without going
// busy. Any start seen while busy is dropped.
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-high; clears all state
//   start  in   1   issue op this cycle
//   op     in   3   000 mult, 001 multu, 010 div, 011 divu,
//                   100 mthi, 101 mtlo, 11x no-op
//   d1     in   32  rs operand (dividend / multiplicand / mthi/mtlo source)
//   d2     in   32  rt operand (divisor / multiplier)
//   busy   out  1   operation in progress (registered)
//   hi     out  32  HI register (registered)
//   lo     out  32  LO register (registered)
//
// The result is computed from the captured operands and written on the final
// edge of the busy period. Every path from the operand registers to hi/lo may
// therefore be treated as a multicycle path of MULT_CYCLES/DIV_CYCLES.
// -----------------------------------------------------------------------------
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int DATA_W = 32;
  localparam int MAX_N  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  // Only the arithmetic ops are ever captured, so op[2] is always 0 here.
  // bit1 = divide, bit0 = unsigned.
  logic [1:0]         op_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;

  // 64-bit product. The operands are sign- or zero-extended to 64 bits, so
  // the low 64 bits of the product are exact for both signednesses.
  function automatic logic [2*DATA_W-1:0] mul_result(
    input logic              is_signed,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] ea;
    logic signed [2*DATA_W-1:0] eb;
    logic signed [2*DATA_W-1:0] p;
    ea = $signed({{DATA_W{is_signed & a[DATA_W-1]}}, a});
    eb = $signed({{DATA_W{is_signed & b[DATA_W-1]}}, b});
    p  = ea * eb;
    return $unsigned(p);
  endfunction

  // Returns {remainder, quotient}. Signed division is done on magnitudes and
  // the signs are fixed up afterwards. The quotient truncates toward zero and
  // the remainder takes the sign of the dividend. For 0x80000000 / -1 the
  // magnitude of the dividend is 0x80000000 and no negation is applied, so
  // the quotient wraps to 0x80000000 with a zero remainder.
  function automatic logic [2*DATA_W-1:0] div_result(
    input logic              is_signed,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic              neg_a;
    logic              neg_b;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] uq;
    logic [DATA_W-1:0] ur;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    neg_a = is_signed & a[DATA_W-1];
    neg_b = is_signed & b[DATA_W-1];
    mag_a = neg_a ? (~a + DATA_W'(1)) : a;
    mag_b = neg_b ? (~b + DATA_W'(1)) : b;
    uq    = mag_a / mag_b;
    ur    = mag_a % mag_b;
    q     = (neg_a ^ neg_b) ? (~uq + DATA_W'(1)) : uq;
    r     = neg_a ? (~ur + DATA_W'(1)) : ur;
    return {r, q};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                op_q  <= op[1:0];
                a_q   <= d1;
                b_q   <= d2;
                cnt   <= CNT_W'(MULT_CYCLES - 1);
                busy  <= 1'b1;
                state <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                op_q  <= op[1:0];
                a_q   <= d1;
                b_q   <= d2;
                cnt   <= CNT_W'(DIV_CYCLES - 1);
                busy  <= 1'b1;
                state <= RUN;
              end
              OP_MTHI: hi <= d1;
              OP_MTLO: lo <= d1;
              default: ;
            endcase
          end
        end
        RUN: begin
          // start is ignored for the whole RUN state, including the final edge.
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (!op_q[1]) begin
              {hi, lo} <= mul_result(~op_q[0], a_q, b_q);
            end else if (b_q != '0) begin
              // A divide by zero still uses the full latency but leaves HI/LO unchanged.
              {hi, lo} <= div_result(~op_q[0], a_q, b_q);
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
